// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding, lamp pattern type and default phase durations.
// Optional TRAFFIC_FLASH_EN adds the FLASH state.
package traffic_pkg;

    typedef enum logic [3:0] {
        ALLRED_NS, NS_RA, NS_G, NS_A, ALLRED_EW, EW_RA, EW_G, EW_A, WALK
`ifdef TRAFFIC_FLASH_EN
        , FLASH
`endif
    } state_e;

    typedef enum logic {DIR_NS, DIR_EW} dir_e;

    typedef struct packed {
        logic red;
        logic amber;
        logic green;
    } lamp_t;

    localparam lamp_t L_OFF   = 3'b000;
    localparam lamp_t L_RED   = 3'b100;
    localparam lamp_t L_RA    = 3'b110;
    localparam lamp_t L_GREEN = 3'b001;
    localparam lamp_t L_AMBER = 3'b010;

    localparam int DEF_GREEN     = 8;
    localparam int DEF_AMBER     = 3;
    localparam int DEF_RED_AMBER = 2;
    localparam int DEF_ALL_RED   = 1;
    localparam int DEF_WALK      = 5;
    localparam int DEF_FLASH     = 4;

    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/traffic_junction_phase_timer.sv
// phase_timer: loadable down-counter with enable and zero flag; holds at zero.
module phase_timer #(
    parameter int           W       = 3,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);
    logic [W-1:0] count_q, count_d;

    always_comb count_d = load_i ? load_val_i : (en_i && count_q != '0) ? count_q - 1'b1 : count_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count_q <= RST_VAL;
        else        count_q <= count_d;

    assign zero_o = count_q == '0;
endmodule

// File: rtl/traffic_junction.sv
// traffic_junction: two-way UK-sequence junction controller with all-red clearance and latched WALK phase.
// Define TRAFFIC_FLASH_EN to add the flash input and the flashing-amber FLASH state.
module traffic_junction
    import traffic_pkg::*;
#(
    parameter int GREEN_CYCLES     = DEF_GREEN,
    parameter int AMBER_CYCLES     = DEF_AMBER,
    parameter int RED_AMBER_CYCLES = DEF_RED_AMBER,
    parameter int ALL_RED_CYCLES   = DEF_ALL_RED,
    parameter int WALK_CYCLES      = DEF_WALK
`ifdef TRAFFIC_FLASH_EN
    , parameter int FLASH_HALF     = DEF_FLASH
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic ped_req,
`ifdef TRAFFIC_FLASH_EN
    input  logic flash,
`endif
    output logic ns_red,
    output logic ns_amber,
    output logic ns_green,
    output logic ew_red,
    output logic ew_amber,
    output logic ew_green,
    output logic walk,
    output logic ped_ack
);
`ifdef TRAFFIC_FLASH_EN
    localparam int MAXD = max2(max2(max2(GREEN_CYCLES, AMBER_CYCLES), max2(RED_AMBER_CYCLES, ALL_RED_CYCLES)),
                               max2(WALK_CYCLES, FLASH_HALF));
`else
    localparam int MAXD = max2(max2(max2(GREEN_CYCLES, AMBER_CYCLES), max2(RED_AMBER_CYCLES, ALL_RED_CYCLES)),
                               WALK_CYCLES);
`endif
    localparam int TW = MAXD > 1 ? $clog2(MAXD) : 1;

    state_e        state_q, state_d;
    dir_e          dir_q, dir_d;
    logic          ped_q, ped_d, ack_q, enter_walk;
    logic          tmr_zero, tmr_load, tmr_en;
    logic [TW-1:0] tmr_val;
    int            dur;
    lamp_t         ns_l, ew_l;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        if (en && tmr_zero) begin
            case (state_q)
                ALLRED_NS: state_d = NS_RA;
                NS_RA:     state_d = NS_G;
                NS_G:      state_d = NS_A;
                NS_A: begin
                    state_d = ped_q ? WALK : ALLRED_EW;
                    dir_d   = DIR_EW;
                end
                ALLRED_EW: state_d = EW_RA;
                EW_RA:     state_d = EW_G;
                EW_G:      state_d = EW_A;
                EW_A: begin
                    state_d = ped_q ? WALK : ALLRED_NS;
                    dir_d   = DIR_NS;
                end
                WALK:      state_d = dir_q == DIR_EW ? ALLRED_EW : ALLRED_NS;
                default:   state_d = ALLRED_NS;
            endcase
        end
`ifdef TRAFFIC_FLASH_EN
        if (flash)                 state_d = FLASH;
        else if (state_q == FLASH) state_d = ALLRED_NS;
`endif
    end

    always_comb begin
        case (state_d)
            NS_RA, EW_RA: dur = RED_AMBER_CYCLES;
            NS_G, EW_G:   dur = GREEN_CYCLES;
            NS_A, EW_A:   dur = AMBER_CYCLES;
            WALK:         dur = WALK_CYCLES;
`ifdef TRAFFIC_FLASH_EN
            FLASH:        dur = FLASH_HALF;
`endif
            default:      dur = ALL_RED_CYCLES;
        endcase
    end

    assign tmr_val    = TW'(dur - 1);
    assign enter_walk = state_d == WALK && state_q != WALK;

`ifdef TRAFFIC_FLASH_EN
    logic amb_q, amb_d;
    // The flash half-period runs from the same timer, free of en.
    assign tmr_load = state_d != state_q || (state_q == FLASH && tmr_zero);
    assign tmr_en   = en || state_q == FLASH;
    assign amb_d    = state_q != FLASH ? 1'b1 : tmr_zero ? ~amb_q : amb_q;
    assign ped_d    = state_q == FLASH ? ped_q : enter_walk ? 1'b0 : ped_q | ped_req;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) amb_q <= 1'b1;
        else        amb_q <= amb_d;
`else
    assign tmr_load = state_d != state_q;
    assign tmr_en   = en;
    assign ped_d    = enter_walk ? 1'b0 : ped_q | ped_req;
`endif

    phase_timer #(.W(TW), .RST_VAL(TW'(ALL_RED_CYCLES - 1))) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .en_i      (tmr_en),
        .zero_o    (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= ALLRED_NS;
            dir_q   <= DIR_NS;
            ped_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            ped_q   <= ped_d;
            ack_q   <= enter_walk;
        end

    always_comb begin
        ns_l = L_RED;
        ew_l = L_RED;
        walk = 1'b0;
        case (state_q)
            NS_RA: ns_l = L_RA;
            NS_G:  ns_l = L_GREEN;
            NS_A:  ns_l = L_AMBER;
            EW_RA: ew_l = L_RA;
            EW_G:  ew_l = L_GREEN;
            EW_A:  ew_l = L_AMBER;
            WALK:  walk = 1'b1;
`ifdef TRAFFIC_FLASH_EN
            FLASH: begin
                ns_l = amb_q ? L_AMBER : L_OFF;
                ew_l = amb_q ? L_AMBER : L_OFF;
            end
`endif
            default: ;
        endcase
    end

    assign {ns_red, ns_amber, ns_green} = ns_l;
    assign {ew_red, ew_amber, ew_green} = ew_l;
    assign ped_ack = ack_q;
endmodule

// File: tb/tb_traffic_junction.sv
// tb_traffic_junction: directed checks of sequencing, reset, pedestrian handshake and enable freeze.
module tb_traffic_junction;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, ped_req = 1'b0;
    logic ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk, ped_ack;
`ifdef TRAFFIC_FLASH_EN
    logic flash = 1'b0;
`endif
    logic [7:0] obs, seq[28];
    int checks = 0, errors = 0, pos = 0, n = 0;

    // {ns_r, ns_a, ns_g, ew_r, ew_a, ew_g, walk, ped_ack}
    localparam logic [7:0] P_AR = 8'h90, P_NRA = 8'hD0, P_NG = 8'h30, P_NA = 8'h50;
    localparam logic [7:0] P_ERA = 8'h98, P_EG = 8'h84, P_EA = 8'h88, P_WK = 8'h92, P_WKA = 8'h93;

    traffic_junction dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .ped_req (ped_req),
`ifdef TRAFFIC_FLASH_EN
        .flash   (flash),
`endif
        .ns_red  (ns_red),
        .ns_amber(ns_amber),
        .ns_green(ns_green),
        .ew_red  (ew_red),
        .ew_amber(ew_amber),
        .ew_green(ew_green),
        .walk    (walk),
        .ped_ack (ped_ack)
    );

    always #5 clk = ~clk;
    assign obs = {ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk, ped_ack};

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input logic [7:0] p, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            seq[n] = p;
            n++;
        end
    endtask

    task automatic expect_seq(input string tag, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            chk(tag, obs, seq[pos % 28]);
            step();
            pos++;
        end
    endtask

    initial begin
        add(P_AR, 1); add(P_NRA, 2); add(P_NG, 8); add(P_NA, 3);
        add(P_AR, 1); add(P_ERA, 2); add(P_EG, 8); add(P_EA, 3);
        #1 chk("rst_hold", obs, P_AR);
        step();
        chk("rst_hold2", obs, P_AR);
        rst_n = 1'b1;
        pos = 0;
        expect_seq("free", 56);
        expect_seq("pre_rst", 5);
        chk("mid_green", obs, P_NG);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", obs, P_AR);
        @(negedge clk);
        chk("rst_held", obs, P_AR);
        rst_n = 1'b1;
        pos = 0;
        expect_seq("after_rst", 5);
        ped_req = 1'b1;
        expect_seq("ped_green", 1);
        ped_req = 1'b0;
        expect_seq("ped_amber", 8);
        chk("ped_ack", obs, P_WKA);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("ped_walk", obs, P_WK);
            step();
        end
        pos = 14;
        expect_seq("ped_ew", 12);
        chk("frz_pre", obs, P_EA);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("frz_hold", obs, P_EA);
        end
        en = 1'b1;
        step();
        pos = 27;
        expect_seq("frz_post", 12);
        ped_req = 1'b1;
        expect_seq("col_amber", 3);
        chk("col_ack1", obs, P_WKA);
        step();
        ped_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("col_walk1", obs, P_WK);
            step();
        end
        pos = 14;
        expect_seq("col_ew", 14);
        chk("col_ack2", obs, P_WKA);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("col_walk2", obs, P_WK);
            step();
        end
        pos = 0;
        expect_seq("col_clear", 28);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
